// File: rtl/cpm_pkg.sv
// Shared defaults and drain FSM state type for the CPM top-K sorter datapath.
package cpm_pkg;

  localparam int CPM_DATA_DW = 8;
  localparam int CPM_INFO_DW = 8;
  localparam int CPM_SORT_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } drain_state_t;

endpackage

// File: rtl/cpm_topk_sel.sv
// Registered SORT_DW:1 selector of {DAT,INF} by index; with CPM_DRAIN_THR_EN it also
// registers whether the entry after the selected one falls below the threshold.
module cpm_topk_sel
  import cpm_pkg::*;
#(
  parameter int DATA_DW = CPM_DATA_DW,
  parameter int INFO_DW = CPM_INFO_DW,
  parameter int SORT_DW = CPM_SORT_DW,
  parameter int SORT_AW = $clog2(SORT_DW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic [SORT_AW-1:0]         sel,
  input  logic [SORT_DW*DATA_DW-1:0] src_dat,
  input  logic [SORT_DW*INFO_DW-1:0] src_inf,
`ifdef CPM_DRAIN_THR_EN
  input  logic [DATA_DW-1:0]         thr,
  output logic                       below_next,
`endif
  output logic [DATA_DW-1:0]         dat,
  output logic [INFO_DW-1:0]         inf
);

  logic [DATA_DW-1:0] pick_dat;
  logic [INFO_DW-1:0] pick_inf;
`ifdef CPM_DRAIN_THR_EN
  logic [DATA_DW-1:0] next_dat;
  logic               next_ok;
`endif

  always_comb begin
    pick_dat = '0;
    pick_inf = '0;
`ifdef CPM_DRAIN_THR_EN
    next_dat = '0;
    next_ok  = 1'b0;
`endif
    for (int unsigned i = 0; i < SORT_DW; i++) begin
      if (sel == SORT_AW'(i)) begin
        pick_dat = src_dat[i*DATA_DW +: DATA_DW];
        pick_inf = src_inf[i*INFO_DW +: INFO_DW];
      end
`ifdef CPM_DRAIN_THR_EN
      if (i == 32'(sel) + 32'd1) begin
        next_dat = src_dat[i*DATA_DW +: DATA_DW];
        next_ok  = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat <= '0;
      inf <= '0;
`ifdef CPM_DRAIN_THR_EN
      below_next <= 1'b0;
`endif
    end else if (clear) begin
      dat <= '0;
      inf <= '0;
`ifdef CPM_DRAIN_THR_EN
      below_next <= 1'b0;
`endif
    end else if (load) begin
      dat <= pick_dat;
      inf <= pick_inf;
`ifdef CPM_DRAIN_THR_EN
      below_next <= next_ok && (next_dat < thr);
`endif
    end
  end

endmodule

// File: rtl/cpm_topk_drain.sv
// Snapshots the sorted top-K array on TOPK_DAT_VLD rise and streams the first N entries.
// Optional early stop below a threshold when CPM_DRAIN_THR_EN is defined.
module cpm_topk_drain
  import cpm_pkg::*;
#(
  parameter int DATA_DW = CPM_DATA_DW,
  parameter int INFO_DW = CPM_INFO_DW,
  parameter int SORT_DW = CPM_SORT_DW,
  parameter int SORT_AW = $clog2(SORT_DW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       TOPK_DAT_VLD,
  input  logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT,
  input  logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF,
  input  logic [SORT_AW:0]           CFG_NUM,
`ifdef CPM_DRAIN_THR_EN
  input  logic [DATA_DW-1:0]         CFG_THR,
`endif
  output logic                       OUT_DAT_VLD,
  input  logic                       OUT_DAT_RDY,
  output logic                       OUT_DAT_LST,
  output logic [DATA_DW-1:0]         OUT_DAT_DAT,
  output logic [INFO_DW-1:0]         OUT_DAT_INF,
  output logic [SORT_AW-1:0]         OUT_DAT_IDX,
  output logic                       BUSY
);

  localparam logic [SORT_AW:0] NUM_MAX = (SORT_AW+1)'(SORT_DW);

  drain_state_t               state_q, state_d;
  logic                       vld_prev;
  logic [SORT_DW*DATA_DW-1:0] snap_dat;
  logic [SORT_DW*INFO_DW-1:0] snap_inf;
  logic [SORT_AW:0]           num_q, num_new;
  logic [SORT_AW-1:0]         idx_q, idx_nxt;
  logic                       lst_q, lst_raw;
  logic                       rise, capture, fire, advance, empty;
`ifdef CPM_DRAIN_THR_EN
  logic [DATA_DW-1:0]         thr_q;
  logic                       below_next;
`endif

  assign rise    = TOPK_DAT_VLD & ~vld_prev;
  assign capture = (state_q == IDLE) & rise & ~clear;
  assign num_new = (CFG_NUM > NUM_MAX) ? NUM_MAX : CFG_NUM;
  assign idx_nxt = idx_q + 1'b1;

  assign OUT_DAT_VLD = (state_q == SEND);
  assign BUSY        = (state_q == SEND);
  assign OUT_DAT_IDX = idx_q;
  assign fire        = OUT_DAT_VLD & OUT_DAT_RDY;
  assign advance     = fire & ~OUT_DAT_LST;

`ifdef CPM_DRAIN_THR_EN
  // Sorted descending: entry 0 below threshold means nothing qualifies.
  assign empty   = (num_new == '0) | (TOPK_DAT_DAT[DATA_DW-1:0] < CFG_THR);
  assign lst_raw = lst_q | below_next;
`else
  assign empty   = (num_new == '0);
  assign lst_raw = lst_q;
`endif
  assign OUT_DAT_LST = OUT_DAT_VLD & lst_raw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = empty ? DONE : SEND;
      SEND:    if (fire && OUT_DAT_LST) state_d = DONE;
      DONE:    if (!TOPK_DAT_VLD) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vld_prev <= 1'b0;
      snap_dat <= '0;
      snap_inf <= '0;
      num_q    <= '0;
      idx_q    <= '0;
      lst_q    <= 1'b0;
`ifdef CPM_DRAIN_THR_EN
      thr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vld_prev <= TOPK_DAT_VLD;
      if (clear) begin
        snap_dat <= '0;
        snap_inf <= '0;
        num_q    <= '0;
        idx_q    <= '0;
        lst_q    <= 1'b0;
`ifdef CPM_DRAIN_THR_EN
        thr_q    <= '0;
`endif
      end else if (capture) begin
        snap_dat <= TOPK_DAT_DAT;
        snap_inf <= TOPK_DAT_INF;
        num_q    <= num_new;
        idx_q    <= '0;
        lst_q    <= (num_new == (SORT_AW+1)'(1));
`ifdef CPM_DRAIN_THR_EN
        thr_q    <= CFG_THR;
`endif
      end else if (advance) begin
        idx_q <= idx_nxt;
        lst_q <= ({1'b0, idx_nxt} == num_q - 1'b1);
      end
    end
  end

  // On the snapshot cycle the selector reads the live array so beat 0 is ready one cycle after the edge.
  cpm_topk_sel #(
    .DATA_DW(DATA_DW),
    .INFO_DW(INFO_DW),
    .SORT_DW(SORT_DW),
    .SORT_AW(SORT_AW)
  ) u_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .load      (capture | advance),
    .sel       (capture ? '0 : idx_nxt),
    .src_dat   (capture ? TOPK_DAT_DAT : snap_dat),
    .src_inf   (capture ? TOPK_DAT_INF : snap_inf),
`ifdef CPM_DRAIN_THR_EN
    .thr       (capture ? CFG_THR : thr_q),
    .below_next(below_next),
`endif
    .dat       (OUT_DAT_DAT),
    .inf       (OUT_DAT_INF)
  );

endmodule

// File: tb/tb_cpm_topk_drain.sv
// Scoreboard bench for cpm_topk_drain: a list-based model queues expected beats, a monitor checks them.
module tb_cpm_topk_drain;
  localparam int DATA_DW = 8;
  localparam int INFO_DW = 8;
  localparam int SORT_DW = 32;
  localparam int SORT_AW = 5;
`ifdef CPM_DRAIN_THR_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] dat;
    logic [7:0] inf;
    int         idx;
    bit         lst;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       rst_n, clear, topk_vld;
  logic [SORT_DW*DATA_DW-1:0] topk_dat;
  logic [SORT_DW*INFO_DW-1:0] topk_inf;
  logic [SORT_AW:0]           cfg_num;
  logic [DATA_DW-1:0]         cfg_thr;
  logic                       out_vld, out_rdy, out_lst, busy;
  logic [DATA_DW-1:0]         out_dat;
  logic [INFO_DW-1:0]         out_inf;
  logic [SORT_AW-1:0]         out_idx;

  int    checks = 0;
  int    failures = 0;
  int    busy_cnt = 0;
  int    rdy_mode = 4;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];
  logic [7:0] adat[SORT_DW];
  logic [7:0] ainf[SORT_DW];

  always #5 clk = ~clk;

  cpm_topk_drain #(
    .DATA_DW(DATA_DW),
    .INFO_DW(INFO_DW),
    .SORT_DW(SORT_DW),
    .SORT_AW(SORT_AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .TOPK_DAT_VLD(topk_vld),
    .TOPK_DAT_DAT(topk_dat),
    .TOPK_DAT_INF(topk_inf),
    .CFG_NUM     (cfg_num),
`ifdef CPM_DRAIN_THR_EN
    .CFG_THR     (cfg_thr),
`endif
    .OUT_DAT_VLD (out_vld),
    .OUT_DAT_RDY (out_rdy),
    .OUT_DAT_LST (out_lst),
    .OUT_DAT_DAT (out_dat),
    .OUT_DAT_INF (out_inf),
    .OUT_DAT_IDX (out_idx),
    .BUSY        (busy)
  );

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: pops on every handshake; with nothing expected the output must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (exp_q.size() == 0) begin
        chk("idle_vld", out_vld, 0);
        chk("idle_busy", busy, 0);
      end else if (out_vld && out_rdy) begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_dat", out_dat, e.dat);
        chk("beat_inf", out_inf, e.inf);
        chk("beat_idx", out_idx, e.idx);
        chk("beat_lst", out_lst, e.lst);
      end
    end
  end

  // Consumer ready pattern: 0 always, 1 toggle, 2 random, other values leave it to the caller.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ~out_rdy;
        2: out_rdy = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic load_array(input int kind);
    int v;
    v = 255;
    for (int i = 0; i < SORT_DW; i++) begin
      case (kind)
        1: adat[i] = 8'(31 - i);
        2: adat[i] = (i < 5) ? 8'(50 - 10 * i) : 8'd0;
        default: begin
          adat[i] = 8'(v);
          v = v - int'($urandom_range(0, 7));
        end
      endcase
      ainf[i] = 8'($urandom);
    end
  endtask

  task automatic start_stream(input int num, input int thr, output int nb);
    beat_t lst[$];
    int n;
    n = (num > SORT_DW) ? SORT_DW : num;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      if (THR_EN && int'(adat[i]) < thr) break;
      b.dat = adat[i];
      b.inf = ainf[i];
      b.idx = i;
      b.lst = 1'b0;
      lst.push_back(b);
    end
    nb = lst.size();
    if (nb > 0) lst[nb-1].lst = 1'b1;
    foreach (lst[i]) exp_q.push_back(lst[i]);
    for (int i = 0; i < SORT_DW; i++) begin
      topk_dat[i*DATA_DW +: DATA_DW] = adat[i];
      topk_inf[i*INFO_DW +: INFO_DW] = ainf[i];
    end
    cfg_num  = (SORT_AW+1)'(num);
    cfg_thr  = 8'(thr);
    topk_vld = 1'b1;
  endtask

  task automatic run_trial(input int kind, input int num, input int thr, input int mode, input int hold);
    int nb;
    @(posedge clk);
    #1;
    rdy_mode = mode;
    busy_cnt = 0;
    load_array(kind);
    start_stream(num, thr, nb);
    @(posedge clk);
    #1;
    topk_dat = {8{$urandom}};
    topk_inf = {8{$urandom}};
    cfg_num  = (SORT_AW+1)'($urandom);
    cfg_thr  = 8'($urandom);
    @(negedge clk);
    chk("first_vld_latency", out_vld, (nb > 0));
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (hold) @(posedge clk);
    #1;
    topk_vld = 1'b0;
    repeat (3) @(posedge clk);
    if (mode == 0) chk("busy_cycles", busy_cnt, nb);
  endtask

  task automatic clear_test();
    int nb;
    @(posedge clk);
    #1;
    rdy_mode = 4;
    out_rdy  = 1'b1;
    load_array(0);
    start_stream(8, 0, nb);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    @(posedge clk);
    #1;
    clear    = 1'b1;
    topk_vld = 1'b0;
    chk("beats_before_clear", nb - exp_q.size(), 2);
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    topk_vld = 1'b0;
    topk_dat = '0;
    topk_inf = '0;
    cfg_num  = '0;
    cfg_thr  = '0;
    out_rdy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld", out_vld, 0);
    chk("rst_lst", out_lst, 0);
    chk("rst_dat", out_dat, 0);
    chk("rst_inf", out_inf, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    mon_en = 1'b1;

    run_trial(1, 4, 0, 0, 2);
    run_trial(0, 40, 0, 0, 2);
    run_trial(0, 3, 0, 1, 2);
    clear_test();
    run_trial(0, 8, 0, 0, 2);
    run_trial(0, 0, 0, 0, 20);
    run_trial(0, 1, 0, 2, 2);
    if (THR_EN) run_trial(2, 8, 35, 0, 2);
    for (int t = 0; t < 25; t++)
      run_trial(0, int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 2)), int'($urandom_range(1, 5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
